checkpoint_monitor: RTL and testbench
=====================================

# checkpoint_monitor

Synthesizable firmware-progress monitor in the user project area. Management firmware writes 16-bit checkpoint codes, the same codes the chip-level benches poll on mprj_io[31:16]. The block checks them against a programmable ordered list and enforces a per-stage timeout. It reports pass, fail and the failure cause on registered outputs, so silicon self-checks the same sequence the simulation benches watch.

## Interface
Parameters:
- WIDTH, 16, checkpoint code width
- NUM_CHK, 4, number of ordered checkpoints (2..16)
- TIMEOUT_CYC, 7000, cycles allowed per stage before timeout fail
- TW, 16, timeout counter width; must satisfy TIMEOUT_CYC < 2**TW

Ports:
- clock  in  1  single system clock
- resetb  in  1  asynchronous, active-low reset
- cfg_we  in  1  write expected-code table entry
- cfg_idx  in  $clog2(NUM_CHK)  table index
- cfg_data  in  WIDTH  expected code
- start_i  in  1  one-cycle pulse; arms monitor, clears result
- status_valid_i  in  1  status_i sample strobe
- status_i  in  WIDTH  checkpoint code from firmware
- busy_o  out  1  ARMED or TRACK
- pass_o  out  1  sticky pass
- fail_o  out  1  sticky fail
- fail_code_o  out  2  0 none, 1 timeout, 2 bad value
- stage_o  out  $clog2(NUM_CHK+1)  checkpoints matched so far

## Operation
- States: IDLE, ARMED, TRACK, PASS, FAIL.
- Reset:
  - state IDLE; all outputs 0; expected table cleared to 0; timer 0.
- Table writes:
  - cfg_we writes exp[cfg_idx] only when busy_o is 0; ignored otherwise.
  - cfg_idx >= NUM_CHK is ignored.
- IDLE / PASS / FAIL:
  - start_i: stage 0, timer 0, pass/fail/fail_code cleared, go to ARMED.
- ARMED:
  - Waits for the first valid nonzero status. Zero samples are ignored.
  - If the sample equals exp[0], stage becomes 1 and the state goes to TRACK.
  - Any other nonzero sample gives FAIL, code 2.
- TRACK:
  - Valid sample == exp[stage]: stage+1, timer reset to 0.
  - Valid sample == exp[stage-1] (firmware re-write), or zero: ignored.
  - Any other valid sample: FAIL, code 2.
  - When stage reaches NUM_CHK: PASS.
- start_i in ARMED or TRACK restarts, as from IDLE.
- start_i coincident with status_valid_i: start wins, sample dropped.
- Timeout (only with macro, see Configuration):
  - timer increments every cycle in ARMED/TRACK, saturating at TIMEOUT_CYC.
  - Reaching TIMEOUT_CYC gives FAIL, code 1.
  - A match on the same cycle as expiry wins (advance, no fail).
- PASS and FAIL are sticky until start_i or reset. Samples there are ignored.

## Timing
- All outputs are registered.
- pass_o, fail_o and stage_o update one cycle after the deciding sample edge.
- Timeout fail is asserted exactly TIMEOUT_CYC+1 cycles after the last advance or start.
- resetb assertion mid-TRACK clears everything immediately, asynchronously. Deassertion must be synchronized externally to clock.
- Throughput: one sample per cycle; back-to-back matches advance one stage per cycle.

## Configuration
- CHKMON_TIMEOUT_EN defined: timer, TIMEOUT_CYC check and fail_code 1 are present.
- Undefined:
  - timer logic is removed and fail_code 1 is never produced.
  - The monitor waits indefinitely in ARMED/TRACK.
  - TIMEOUT_CYC and TW are unused.

## Structure
- Shared package chkmon_pkg holds:
  - state enum (IDLE, ARMED, TRACK, PASS, FAIL);
  - fail-code constants FC_NONE=0, FC_TIMEOUT=1, FC_BADVAL=2.
- One sub-module, chkmon_timer:
  - saturating stage timer with clear input and expired output;
  - instantiated only under CHKMON_TIMEOUT_EN.

## Test plan
- Sequence pass:
  - Stimulus: table {AB60,AB61,AB62,AB63}; start; valid samples AB60, AB61, AB62, AB63, spaced 10 cycles.
  - Response: stage_o steps 1..4; pass_o=1 one cycle after AB63; fail_o=0.
- Repeat tolerance:
  - Stimulus: AB60, AB60, 0000, AB61.
  - Response: stage_o=2; no fail.
- Bad value:
  - Stimulus: AB60 then AB62.
  - Response: fail_o=1, fail_code_o=2, stage_o=1.
- Timeout (macro on, TIMEOUT_CYC=20):
  - Stimulus: start, then no samples.
  - Response: fail_o=1, code 1, 21 cycles after start.
  - Also: a match landing on the expiry cycle advances instead of failing.
- Restart and reset:
  - Stimulus: start mid-TRACK at stage 2.
  - Response: stage_o=0, busy_o=1.
  - Stimulus: start coincident with a valid AB60.
  - Response: stage stays 0.
  - Stimulus: resetb low mid-TRACK.
  - Response: all outputs 0 with no clock edge.
- Config lockout:
  - Stimulus: cfg_we of exp[1]=FFFF while busy; then AB61 sent at stage 1.
  - Response: AB61 still advances stage to 2.

Source files
------------

// File: rtl/chkmon_pkg.sv
// chkmon_pkg: shared definitions for the checkpoint monitor.
//   chkmon_state_e : monitor FSM state encoding
//   FC_*           : fail_code_o values reported on a failure
package chkmon_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARMED = 3'd1,
    TRACK = 3'd2,
    PASS  = 3'd3,
    FAIL  = 3'd4
  } chkmon_state_e;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_TIMEOUT = 2'd1;
  localparam logic [1:0] FC_BADVAL  = 2'd2;

endpackage

// File: rtl/checkpoint_monitor_if.sv
// checkpoint_monitor_if: configuration, firmware status and result signals
// of the checkpoint monitor.
//   cfg_we/cfg_idx/cfg_data : expected-code table write port
//   start_i                 : one-cycle arm/restart pulse
//   status_valid_i/status_i : checkpoint code sample; a sample is taken on
//                             every clock edge where status_valid_i is high.
//                             There is no ready: the monitor accepts one
//                             sample per cycle unconditionally.
//   busy_o/pass_o/fail_o/fail_code_o/stage_o : registered results
//   dbg_state               : current FSM state, for observation only
// master: the firmware/stimulus side; slave: the monitor.
interface checkpoint_monitor_if #(
  parameter int WIDTH   = 16,
  parameter int NUM_CHK = 4
);
  import chkmon_pkg::*;

  localparam int IW = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
  localparam int SW = $clog2(NUM_CHK + 1);

  logic             cfg_we;
  logic [IW-1:0]    cfg_idx;
  logic [WIDTH-1:0] cfg_data;
  logic             start_i;
  logic             status_valid_i;
  logic [WIDTH-1:0] status_i;
  logic             busy_o;
  logic             pass_o;
  logic             fail_o;
  logic [1:0]       fail_code_o;
  logic [SW-1:0]    stage_o;
  chkmon_state_e    dbg_state;

  modport master (
    output cfg_we, cfg_idx, cfg_data, start_i, status_valid_i, status_i,
    input  busy_o, pass_o, fail_o, fail_code_o, stage_o, dbg_state
  );

  modport slave (
    input  cfg_we, cfg_idx, cfg_data, start_i, status_valid_i, status_i,
    output busy_o, pass_o, fail_o, fail_code_o, stage_o, dbg_state
  );

endinterface

// File: rtl/chkmon_timer.sv
// chkmon_timer: saturating per-stage timer.
//   clock, resetb : clock, asynchronous active-low reset
//   en            : count this cycle
//   clr           : restart from 0 (wins over en)
//   expired       : count has reached MAX (held while saturated)
module chkmon_timer #(
  parameter int MAX = 7000,
  parameter int TW  = 16
) (
  input  logic clock,
  input  logic resetb,
  input  logic en,
  input  logic clr,
  output logic expired
);

  logic [TW-1:0] cnt;

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != TW'(MAX))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = (cnt == TW'(MAX));

endmodule

// File: rtl/checkpoint_monitor.sv
// checkpoint_monitor: checks firmware checkpoint codes against a
// programmable ordered table and reports pass/fail on registered outputs.
//   clock, resetb : clock, asynchronous active-low reset
//   bus           : checkpoint_monitor_if.slave (config, samples, results)
// Build option: define CHKMON_TIMEOUT_EN to include the per-stage timeout
// (chkmon_timer, fail code 1). Without it the monitor waits indefinitely
// and TIMEOUT_CYC/TW only feed the configuration sanity check.
module checkpoint_monitor
  import chkmon_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int NUM_CHK     = 4,
  parameter int TIMEOUT_CYC = 7000,
  parameter int TW          = 16
) (
  input  logic                 clock,
  input  logic                 resetb,
  checkpoint_monitor_if.slave  bus
);

  localparam int IW = (NUM_CHK > 1) ? $clog2(NUM_CHK) : 1;
  localparam int SW = $clog2(NUM_CHK + 1);

  if (TIMEOUT_CYC >= (2 ** TW)) begin : g_bad_timeout_cfg
    $error("checkpoint_monitor: TIMEOUT_CYC must be below 2**TW");
  end

  logic [WIDTH-1:0] exp_tbl [NUM_CHK];

  chkmon_state_e state, state_n;
  logic [SW-1:0] stage_q, stage_n, stage_inc;
  logic          pass_q, pass_n;
  logic          fail_q, fail_n;
  logic          busy_q, busy_n;
  logic [1:0]    code_q, code_n;

  logic [IW-1:0] cur_idx, prev_idx;
  logic          sample_nz, hit_cur, hit_prev;
  logic          advance, bad, tmo;
  logic          timer_expired;

  // Expected-code table: writable only while the monitor is not tracking,
  // so a sequence in flight always sees a stable table.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < NUM_CHK; i++) exp_tbl[i] <= '0;
    end else if (bus.cfg_we && !busy_q && (32'(bus.cfg_idx) < NUM_CHK)) begin
      exp_tbl[bus.cfg_idx] <= bus.cfg_data;
    end
  end

`ifdef CHKMON_TIMEOUT_EN
  chkmon_timer #(
    .MAX (TIMEOUT_CYC),
    .TW  (TW)
  ) u_timer (
    .clock   (clock),
    .resetb  (resetb),
    .en      (busy_q),
    .clr     (bus.start_i | advance),
    .expired (timer_expired)
  );
`else
  assign timer_expired = 1'b0;
`endif

  // State and result registers.
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state   <= IDLE;
      stage_q <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      code_q  <= FC_NONE;
    end else begin
      state   <= state_n;
      stage_q <= stage_n;
      pass_q  <= pass_n;
      fail_q  <= fail_n;
      busy_q  <= busy_n;
      code_q  <= code_n;
    end
  end

  // Sample classification. In ARMED stage is 0, so cur_idx selects exp[0];
  // prev_idx is only consulted in TRACK where stage >= 1.
  always_comb begin
    cur_idx   = stage_q[IW-1:0];
    prev_idx  = cur_idx - 1'b1;
    stage_inc = stage_q + 1'b1;
    sample_nz = bus.status_valid_i && (bus.status_i != '0);
    hit_cur   = (bus.status_i == exp_tbl[cur_idx]);
    hit_prev  = (bus.status_i == exp_tbl[prev_idx]);
    advance   = 1'b0;
    bad       = 1'b0;
    tmo       = 1'b0;
    case (state)
      ARMED: begin
        if (sample_nz) begin
          advance = hit_cur;
          bad     = !hit_cur;
        end
        tmo = timer_expired;
      end
      TRACK: begin
        if (sample_nz) begin
          advance = hit_cur;
          bad     = !hit_cur && !hit_prev;
        end
        tmo = timer_expired;
      end
      default: ;
    endcase
  end

  // Next state / results. start_i overrides everything; a match beats a
  // same-cycle expiry, and a bad value is reported ahead of a timeout.
  always_comb begin
    state_n = state;
    stage_n = stage_q;
    pass_n  = pass_q;
    fail_n  = fail_q;
    code_n  = code_q;
    if (bus.start_i) begin
      state_n = ARMED;
      stage_n = '0;
      pass_n  = 1'b0;
      fail_n  = 1'b0;
      code_n  = FC_NONE;
    end else if (advance) begin
      stage_n = stage_inc;
      if (stage_inc == SW'(NUM_CHK)) begin
        state_n = PASS;
        pass_n  = 1'b1;
      end else begin
        state_n = TRACK;
      end
    end else if (bad) begin
      state_n = FAIL;
      fail_n  = 1'b1;
      code_n  = FC_BADVAL;
    end else if (tmo) begin
      state_n = FAIL;
      fail_n  = 1'b1;
      code_n  = FC_TIMEOUT;
    end
    busy_n = (state_n == ARMED) || (state_n == TRACK);
  end

  assign bus.busy_o      = busy_q;
  assign bus.pass_o      = pass_q;
  assign bus.fail_o      = fail_q;
  assign bus.fail_code_o = code_q;
  assign bus.stage_o     = stage_q;
  assign bus.dbg_state   = state;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// tb_checkpoint_monitor: self-checking bench for checkpoint_monitor.
// Every accepted sample pushes its expected stage_o onto exp_q; the
// monitor process pops and compares one cycle after the sample edge.
module tb_checkpoint_monitor;
  import chkmon_pkg::*;

  localparam int WIDTH   = 16;
  localparam int NUM_CHK = 4;
  localparam int TMO     = 20;
  localparam int SW      = $clog2(NUM_CHK + 1);

  logic clock;
  logic resetb;
  int   checks = 0;
  int   errors = 0;
  logic [SW-1:0] exp_q[$];

  checkpoint_monitor_if #(.WIDTH(WIDTH), .NUM_CHK(NUM_CHK)) bus ();

  checkpoint_monitor #(
    .WIDTH       (WIDTH),
    .NUM_CHK     (NUM_CHK),
    .TIMEOUT_CYC (TMO),
    .TW          (16)
  ) dut (
    .clock  (clock),
    .resetb (resetb),
    .bus    (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (time=%0t, limit=200000)", $time);
    $fatal(1, "watchdog");
  end

  // scoreboard monitor
  always @(posedge clock) begin
    if (resetb && bus.status_valid_i && !bus.start_i) begin
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: sample seen with stage_o=%0d but no expected entry", bus.stage_o);
      end else begin
        logic [SW-1:0] e;
        e = exp_q.pop_front();
        if (bus.stage_o !== e) begin
          errors++;
          $display("FAIL sb_stage: stage_o=%0d expected=%0d (t=%0t)", bus.stage_o, e, $time);
        end
      end
    end
  end

  // driver tasks
  task automatic cfg_write(input int idx, input logic [WIDTH-1:0] data);
    @(negedge clock);
    bus.cfg_we   = 1'b1;
    bus.cfg_idx  = idx[1:0];
    bus.cfg_data = data;
    @(negedge clock);
    bus.cfg_we   = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clock);
    bus.start_i = 1'b1;
    @(negedge clock);
    bus.start_i = 1'b0;
  endtask

  task automatic send(input logic [WIDTH-1:0] code, input logic [SW-1:0] exp_stage,
                      input int gap);
    exp_q.push_back(exp_stage);
    @(negedge clock);
    bus.status_valid_i = 1'b1;
    bus.status_i       = code;
    @(negedge clock);
    bus.status_valid_i = 1'b0;
    bus.status_i       = '0;
    repeat (gap) @(negedge clock);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%b expected=%b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scenarios
  task automatic test_reset();
    checks++;
    if ({bus.busy_o, bus.pass_o, bus.fail_o, bus.fail_code_o, bus.stage_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: busy=%b pass=%b fail=%b code=%0d stage=%0d expected all 0",
               bus.busy_o, bus.pass_o, bus.fail_o, bus.fail_code_o, bus.stage_o);
    end
    checks++;
    if (bus.dbg_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d expected=%0d", bus.dbg_state, IDLE);
    end
  endtask

  task automatic test_sequence_pass();
    logic [WIDTH-1:0] tbl [NUM_CHK];
    tbl = '{16'hAB60, 16'hAB61, 16'hAB62, 16'hAB63};
    for (int i = 0; i < NUM_CHK; i++) cfg_write(i, tbl[i]);
    do_start();
    check_bit("pass_busy_armed", bus.busy_o, 1'b1);
    for (int i = 0; i < NUM_CHK; i++) begin
      send(tbl[i], SW'(i + 1), 9);
      if (i == NUM_CHK - 2) check_bit("pass_not_early", bus.pass_o, 1'b0);
    end
    check_bit("pass_pass", bus.pass_o, 1'b1);
    check_bit("pass_nofail", bus.fail_o, 1'b0);
    check_bit("pass_idle_busy", bus.busy_o, 1'b0);
    send(16'hAB60, SW'(NUM_CHK), 1);  // ignored while in PASS
    check_bit("pass_sticky", bus.pass_o, 1'b1);
  endtask

  task automatic test_repeat_tolerance();
    do_start();
    send(16'hAB60, 1, 0);
    send(16'hAB60, 1, 0);
    send(16'h0000, 1, 0);
    send(16'hAB61, 2, 1);
    check_bit("repeat_nofail", bus.fail_o, 1'b0);
    check_bit("repeat_busy", bus.busy_o, 1'b1);
  endtask

  task automatic test_bad_value();
    do_start();
    send(16'hAB60, 1, 0);
    send(16'hAB62, 1, 1);
    check_bit("bad_fail", bus.fail_o, 1'b1);
    checks++;
    if (bus.fail_code_o !== FC_BADVAL) begin
      errors++;
      $display("FAIL bad_code: fail_code_o=%0d expected=%0d", bus.fail_code_o, FC_BADVAL);
    end
    send(16'hAB61, 1, 1);  // ignored while in FAIL
    check_bit("bad_sticky", bus.fail_o, 1'b1);
  endtask

  task automatic test_timeout();
`ifdef CHKMON_TIMEOUT_EN
    do_start();
    repeat (TMO) @(negedge clock);
    check_bit("tmo_not_early", bus.fail_o, 1'b0);
    @(negedge clock);
    check_bit("tmo_fail", bus.fail_o, 1'b1);
    checks++;
    if (bus.fail_code_o !== FC_TIMEOUT) begin
      errors++;
      $display("FAIL tmo_code: fail_code_o=%0d expected=%0d", bus.fail_code_o, FC_TIMEOUT);
    end
    // match landing on the expiry cycle advances instead
    do_start();
    repeat (TMO) @(negedge clock);
    exp_q.push_back(1);
    bus.status_valid_i = 1'b1;
    bus.status_i       = 16'hAB60;
    @(negedge clock);
    bus.status_valid_i = 1'b0;
    bus.status_i       = '0;
    check_bit("tmo_match_wins", bus.fail_o, 1'b0);
    repeat (TMO) @(negedge clock);
    check_bit("tmo_rearm_not_early", bus.fail_o, 1'b0);
    @(negedge clock);
    check_bit("tmo_rearm_fail", bus.fail_o, 1'b1);
`else
    do_start();
    repeat (TMO * 5) @(negedge clock);
    check_bit("notmo_nofail", bus.fail_o, 1'b0);
    check_bit("notmo_busy", bus.busy_o, 1'b1);
`endif
  endtask

  task automatic test_config_lockout();
    do_start();
    send(16'hAB60, 1, 0);
    cfg_write(1, 16'hFFFF);
    send(16'hAB61, 2, 1);
    check_bit("lock_nofail", bus.fail_o, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] seq [NUM_CHK];
    seq = '{16'hAB60, 16'hAB61, 16'hAB62, 16'hAB63};
    do_start();
    for (int i = 0; i < NUM_CHK; i++) begin
      exp_q.push_back(SW'(i + 1));
      @(negedge clock);
      bus.status_valid_i = 1'b1;
      bus.status_i       = seq[i];
    end
    @(negedge clock);
    bus.status_valid_i = 1'b0;
    bus.status_i       = '0;
    check_bit("b2b_pass", bus.pass_o, 1'b1);
  endtask

  task automatic test_restart_and_reset();
    do_start();
    send(16'hAB60, 1, 0);
    send(16'hAB61, 2, 0);
    do_start();
    checks++;
    if (bus.stage_o !== '0) begin
      errors++;
      $display("FAIL restart_stage: stage_o=%0d expected=0", bus.stage_o);
    end
    check_bit("restart_busy", bus.busy_o, 1'b1);
    // start coincident with a valid sample: sample dropped
    @(negedge clock);
    bus.start_i        = 1'b1;
    bus.status_valid_i = 1'b1;
    bus.status_i       = 16'hAB60;
    @(negedge clock);
    bus.start_i        = 1'b0;
    bus.status_valid_i = 1'b0;
    bus.status_i       = '0;
    checks++;
    if (bus.stage_o !== '0) begin
      errors++;
      $display("FAIL start_wins_stage: stage_o=%0d expected=0", bus.stage_o);
    end
    send(16'hAB60, 1, 0);
    send(16'hAB61, 2, 0);
    // asynchronous reset away from any clock edge
    #2 resetb = 1'b0;
    #1;
    checks++;
    if ({bus.busy_o, bus.pass_o, bus.fail_o, bus.fail_code_o, bus.stage_o} !== '0) begin
      errors++;
      $display("FAIL async_reset: busy=%b pass=%b fail=%b code=%0d stage=%0d expected all 0",
               bus.busy_o, bus.pass_o, bus.fail_o, bus.fail_code_o, bus.stage_o);
    end
    @(negedge clock);
    resetb = 1'b1;
    // table was cleared to 0, so AB60 is now a bad value in ARMED
    do_start();
    send(16'hAB60, 0, 1);
    check_bit("reset_tbl_cleared", bus.fail_o, 1'b1);
  endtask

  initial begin
    resetb             = 1'b1;
    bus.cfg_we         = 1'b0;
    bus.cfg_idx        = '0;
    bus.cfg_data       = '0;
    bus.start_i        = 1'b0;
    bus.status_valid_i = 1'b0;
    bus.status_i       = '0;
    #2 resetb = 1'b0;
    #1;
    test_reset();
    repeat (2) @(negedge clock);
    resetb = 1'b1;
    test_sequence_pass();
    test_repeat_tolerance();
    test_bad_value();
    test_timeout();
    test_config_lockout();
    test_back_to_back();
    test_restart_and_reset();
    repeat (3) @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expected entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
